// File: rtl/escape_pkg.sv
// Shared state encoding, output codes and state-class helpers for escape_fsm_gen.
package escape_pkg;

  typedef enum logic [3:0] {
    START      = 4'd0,
    CRUISE     = 4'd1,
    L_TURN     = 4'd2,
    L_STRAIGHT = 4'd3,
    L_RETURN   = 4'd4,
    L_SETTLE   = 4'd5,
    R_TURN     = 4'd6,
    R_STRAIGHT = 4'd7,
    R_RETURN   = 4'd8,
    R_SETTLE   = 4'd9,
    REVERSE    = 4'd10
  } state_e;

  localparam logic [2:0] DIR_STRAIGHT = 3'b011;
  localparam logic [2:0] DIR_LEFT     = 3'b110;
  localparam logic [2:0] DIR_RIGHT    = 3'b001;
  localparam logic [1:0] SPD_RUN      = 2'b01;
  localparam logic [1:0] SPD_STOP     = 2'b00;
  localparam logic [1:0] CH_FWD       = 2'b01;
  localparam logic [1:0] CH_REV       = 2'b10;

  function automatic logic [2:0] dir_of(input state_e s);
    case (s)
      L_TURN, R_RETURN: dir_of = DIR_LEFT;
      R_TURN, L_RETURN: dir_of = DIR_RIGHT;
      default:          dir_of = DIR_STRAIGHT;
    endcase
  endfunction

  // States bounded by the manoeuvre timeout.
  function automatic logic is_timed(input state_e s);
    case (s)
      L_TURN, L_STRAIGHT, L_RETURN,
      R_TURN, R_STRAIGHT, R_RETURN: is_timed = 1'b1;
      default:                      is_timed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/escape_fsm_gen_flag_debounce.sv
// Per-bit flag debouncer: an output bit follows its input only after
// DEBOUNCE consecutive samples of the new value. Resets to all-clear (1).
module flag_debounce #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] flag_i,
  output logic [WIDTH-1:0] flag_o
);

  localparam int unsigned DW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);

  logic [WIDTH-1:0]         q_q, q_d;
  logic [WIDTH-1:0][DW-1:0] cnt_q, cnt_d;

  always_comb begin
    q_d   = q_q;
    cnt_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (flag_i[i] != q_q[i]) begin
        if (cnt_q[i] == LAST) q_d[i] = flag_i[i];
        else                  cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= '1;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign flag_o = q_q;

endmodule

// File: rtl/escape_fsm_gen.sv
// Obstacle-avoidance controller with timed manoeuvres, enable and reverse escape.
// Define ESCAPE_DEBOUNCE_EN to debounce the proximity flags (else 1-cycle register).
module escape_fsm_gen
  import escape_pkg::*;
#(
  parameter int unsigned CW          = 12,
  parameter int unsigned STARTUP_CNT = 200,
  parameter int unsigned SETTLE_CNT  = 50,
  parameter int unsigned REV_CNT     = 100,
  parameter int unsigned TIMEOUT_CNT = 1000,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic       clk_100,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] distance_flag,
  output logic [2:0] dir,
  output logic [1:0] speed,
  output logic [1:0] choose,
  output logic       timeout,
  output logic [3:0] state_dbg
);

  localparam logic [CW-1:0] STARTUP_LAST = CW'(STARTUP_CNT - 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CNT - 1);
  localparam logic [CW-1:0] REV_LAST     = CW'(REV_CNT - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CNT - 1);

  logic [3:0] f;

`ifdef ESCAPE_DEBOUNCE_EN
  flag_debounce #(
    .WIDTH    (4),
    .DEBOUNCE (DEBOUNCE)
  ) u_flag_debounce (
    .clk_i  (clk_100),
    .rst_i  (rst),
    .flag_i (distance_flag),
    .flag_o (f)
  );
`else
  // DEBOUNCE has no effect without the filter.
  localparam int unsigned unused_debounce = DEBOUNCE;
  logic [3:0] f_q;

  always_ff @(posedge clk_100) begin
    if (rst) f_q <= '1;
    else     f_q <= distance_flag;
  end

  assign f = f_q;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          to_d;
  logic [2:0]    dir_q;
  logic [1:0]    speed_q, choose_q;
  logic          timeout_q;

  always_comb begin
    state_d = state_q;
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    if (en) begin
      cnt_d = cnt_inc;
      case (state_q)
        START:      if (cnt_q == STARTUP_LAST) state_d = CRUISE;
        CRUISE: begin
          cnt_d = '0;
          if (!f[1] && !f[0]) state_d = REVERSE;
          else if (!f[1])     state_d = R_TURN;
          else if (!f[0])     state_d = L_TURN;
        end
        L_TURN:     if (f[0])  state_d = L_STRAIGHT;
        L_STRAIGHT: if (!f[2]) state_d = L_RETURN;
        L_RETURN:   if (f[2])  state_d = L_SETTLE;
        R_TURN:     if (f[1])  state_d = R_STRAIGHT;
        R_STRAIGHT: if (!f[3]) state_d = R_RETURN;
        R_RETURN:   if (f[3])  state_d = R_SETTLE;
        L_SETTLE, R_SETTLE:
                    if (cnt_q == SETTLE_LAST) state_d = CRUISE;
        REVERSE: begin
          if (cnt_q == REV_LAST) begin
            if (f[3])      state_d = R_TURN;
            else if (f[2]) state_d = L_TURN;
            else           cnt_d = '0;
          end
        end
        default:    state_d = START;
      endcase
      // Timeout only fires when no regular exit was taken this cycle.
      if (is_timed(state_q) && (state_d == state_q) && (cnt_q == TIMEOUT_LAST)) begin
        state_d = REVERSE;
        to_d    = 1'b1;
      end
      if (state_d != state_q) cnt_d = '0;
    end
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q   <= START;
      cnt_q     <= '0;
      dir_q     <= DIR_STRAIGHT;
      speed_q   <= SPD_STOP;
      choose_q  <= CH_FWD;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_of(state_q);
      speed_q   <= (en && (state_q != START)) ? SPD_RUN : SPD_STOP;
      choose_q  <= (state_q == REVERSE) ? CH_REV : CH_FWD;
      timeout_q <= to_d;
    end
  end

  assign dir       = dir_q;
  assign speed     = speed_q;
  assign choose    = choose_q;
  assign timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_escape_fsm_gen.sv
// Scoreboard bench for escape_fsm_gen: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_escape_fsm_gen;
  import escape_pkg::*;

`ifdef ESCAPE_DEBOUNCE_EN
  localparam int unsigned LAT = 4;
`else
  localparam int unsigned LAT = 1;
`endif
  localparam int unsigned KS = LAT + 1;  // flag change -> state_dbg
  localparam int unsigned KO = LAT + 2;  // flag change -> registered outputs

  localparam int unsigned F_STATE  = 0;
  localparam int unsigned F_DIR    = 1;
  localparam int unsigned F_SPEED  = 2;
  localparam int unsigned F_CHOOSE = 3;
  localparam int unsigned F_TO     = 4;

  localparam logic [3:0] E_DSTR = 4'(DIR_STRAIGHT);
  localparam logic [3:0] E_DL   = 4'(DIR_LEFT);
  localparam logic [3:0] E_DR   = 4'(DIR_RIGHT);
  localparam logic [3:0] E_RUN  = 4'(SPD_RUN);
  localparam logic [3:0] E_STOP = 4'(SPD_STOP);
  localparam logic [3:0] E_FWD  = 4'(CH_FWD);
  localparam logic [3:0] E_REV  = 4'(CH_REV);

  logic       clk_100 = 1'b0;
  logic       rst, en;
  logic [3:0] distance_flag;
  logic [2:0] dir;
  logic [1:0] speed, choose;
  logic       timeout;
  logic [3:0] state_dbg;

  escape_fsm_gen #(
    .CW          (12),
    .STARTUP_CNT (200),
    .SETTLE_CNT  (50),
    .REV_CNT     (100),
    .TIMEOUT_CNT (1000),
    .DEBOUNCE    (4)
  ) dut (
    .clk_100       (clk_100),
    .rst           (rst),
    .en            (en),
    .distance_flag (distance_flag),
    .dir           (dir),
    .speed         (speed),
    .choose        (choose),
    .timeout       (timeout),
    .state_dbg     (state_dbg)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    int unsigned cyc;
    int unsigned fld;
    logic [3:0]  val;
    int unsigned tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk_100) cyc <= cyc + 1;

  function automatic string fname(input int unsigned fld);
    case (fld)
      F_STATE:  fname = "state_dbg";
      F_DIR:    fname = "dir";
      F_SPEED:  fname = "speed";
      F_CHOOSE: fname = "choose";
      default:  fname = "timeout";
    endcase
  endfunction

  function automatic logic [3:0] actual(input int unsigned fld);
    case (fld)
      F_STATE:  actual = state_dbg;
      F_DIR:    actual = {1'b0, dir};
      F_SPEED:  actual = {2'b00, speed};
      F_CHOOSE: actual = {2'b00, choose};
      default:  actual = {3'b000, timeout};
    endcase
  endfunction

  task automatic exp_at(input int unsigned k, input int unsigned fld,
                        input logic [3:0] val, input int unsigned tag);
    exp_t e;
    e.cyc = cyc + k;
    e.fld = fld;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  always @(negedge clk_100) begin
    int unsigned i;
    logic [3:0]  act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        act = actual(sb[i].fld);
        checks++;
        if ((sb[i].cyc != cyc) || (act !== sb[i].val)) begin
          errors++;
          $display("FAIL %s step%0d cyc=%0d: actual=%0h required=%0h",
                   fname(sb[i].fld), sb[i].tag, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic reset_startup(input int unsigned tag);
    rst = 1'b1;
    exp_at(1, F_STATE, START, tag);
    exp_at(1, F_DIR, E_DSTR, tag);
    exp_at(1, F_SPEED, E_STOP, tag);
    exp_at(1, F_CHOOSE, E_FWD, tag);
    exp_at(1, F_TO, 4'd0, tag);
    tick(2);
    rst = 1'b0;
    exp_at(199, F_STATE, START, tag);
    exp_at(200, F_STATE, CRUISE, tag);
    exp_at(200, F_SPEED, E_STOP, tag);
    exp_at(201, F_SPEED, E_RUN, tag);
    exp_at(201, F_DIR, E_DSTR, tag);
    exp_at(201, F_CHOOSE, E_FWD, tag);
    tick(204);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    distance_flag = 4'b1111;
    reset_startup(1);

`ifdef ESCAPE_DEBOUNCE_EN
    distance_flag = 4'b1110;
    tick(3);
    distance_flag = 4'b1111;
    exp_at(6, F_STATE, CRUISE, 10);
    exp_at(6, F_DIR, E_DSTR, 10);
    tick(8);
`endif

    // Left manoeuvre
    distance_flag = 4'b1110;
    exp_at(KS, F_STATE, L_TURN, 2);
    exp_at(KO, F_DIR, E_DL, 2);
    tick(8);
    distance_flag = 4'b1111;
    exp_at(KS, F_STATE, L_STRAIGHT, 2);
    exp_at(KO, F_DIR, E_DSTR, 2);
    tick(8);
    distance_flag = 4'b1011;
    exp_at(KS, F_STATE, L_RETURN, 2);
    exp_at(KO, F_DIR, E_DR, 2);
    tick(8);
    distance_flag = 4'b1111;
    exp_at(KS, F_STATE, L_SETTLE, 2);
    exp_at(KO, F_DIR, E_DSTR, 2);
    exp_at(KS + 49, F_STATE, L_SETTLE, 2);
    exp_at(KS + 50, F_STATE, CRUISE, 2);
    tick(KS + 55);

    // Front fully blocked, reverse then right manoeuvre
    distance_flag = 4'b1100;
    exp_at(KS, F_STATE, REVERSE, 3);
    exp_at(KO, F_CHOOSE, E_REV, 3);
    exp_at(KS + 99, F_STATE, REVERSE, 3);
    exp_at(KS + 100, F_STATE, R_TURN, 3);
    exp_at(KS + 100, F_CHOOSE, E_REV, 3);
    exp_at(KS + 101, F_DIR, E_DR, 3);
    exp_at(KS + 101, F_CHOOSE, E_FWD, 3);
    tick(KS + 104);
    distance_flag = 4'b1111;
    exp_at(KS, F_STATE, R_STRAIGHT, 3);
    exp_at(KO, F_DIR, E_DSTR, 3);
    tick(8);
    distance_flag = 4'b0111;
    exp_at(KS, F_STATE, R_RETURN, 3);
    exp_at(KO, F_DIR, E_DL, 3);
    tick(8);
    distance_flag = 4'b1111;
    exp_at(KS, F_STATE, R_SETTLE, 3);
    exp_at(KS + 50, F_STATE, CRUISE, 3);
    tick(KS + 55);

    // Exit condition coincides with timeout: exit wins, no pulse
    distance_flag = 4'b1110;
    exp_at(KS, F_STATE, L_TURN, 4);
    tick(1000);
    distance_flag = 4'b1111;
    exp_at(KS - 1, F_STATE, L_TURN, 4);
    exp_at(KS, F_STATE, L_STRAIGHT, 4);
    exp_at(KS, F_TO, 4'd0, 4);
    exp_at(KS + 1, F_TO, 4'd0, 4);
    tick(KS + 8);

    // en=0 for 30 cycles in L_STRAIGHT; timeout lands 30 cycles late
    en = 1'b0;
    exp_at(1, F_SPEED, E_STOP, 5);
    exp_at(15, F_DIR, E_DSTR, 5);
    exp_at(30, F_SPEED, E_STOP, 5);
    exp_at(30, F_STATE, L_STRAIGHT, 5);
    exp_at(31, F_SPEED, E_RUN, 5);
    tick(30);
    en = 1'b1;
    exp_at(991, F_STATE, L_STRAIGHT, 5);
    exp_at(991, F_TO, 4'd0, 5);
    exp_at(992, F_STATE, REVERSE, 5);
    exp_at(992, F_TO, 4'd1, 5);
    exp_at(993, F_TO, 4'd0, 5);
    exp_at(993, F_CHOOSE, E_REV, 5);
    tick(996);

    // Reset in the middle of REVERSE
    reset_startup(6);

    // Plain timeout in L_TURN
    distance_flag = 4'b1110;
    exp_at(KS, F_STATE, L_TURN, 7);
    exp_at(KS + 999, F_STATE, L_TURN, 7);
    exp_at(KS + 999, F_TO, 4'd0, 7);
    exp_at(KS + 1000, F_STATE, REVERSE, 7);
    exp_at(KS + 1000, F_TO, 4'd1, 7);
    exp_at(KS + 1001, F_TO, 4'd0, 7);
    exp_at(KS + 1001, F_CHOOSE, E_REV, 7);
    exp_at(KS + 1001, F_DIR, E_DSTR, 7);
    tick(KS + 1005);

    tick(2);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard: actual=%0d unchecked entries required=0", sb.size());
      errors = errors + sb.size();
      checks = checks + sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
